// File: rtl/interface_parallel_hs_if.sv
// Host-side FIFO port and peer handshake strobes of interface_parallel_hs.
// The shared ext_data bus stays a plain inout on the block itself.
// Optional feature macro: IFP_TIMEOUT_EN (adds the sticky err_tmo flag).
interface interface_parallel_hs_if #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ADDRESS_WIDTH = 6
);
  logic                    ext_dir;
  logic                    ext_stb_in;
  logic                    ext_ack_out;
  logic                    ext_stb_out;
  logic                    ext_ack_in;
  logic                    wr_en;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic                    rd_en;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic                    rx_empty;
  logic                    rx_full;
  logic                    tx_empty;
  logic                    tx_full;
  logic [ADDRESS_WIDTH:0]  rx_level;
  logic [ADDRESS_WIDTH:0]  tx_level;
  logic                    err_ovf;
  logic                    err_udf;
  logic                    err_clr;
`ifdef IFP_TIMEOUT_EN
  logic                    err_tmo;

  modport slave (
    input  ext_stb_in, ext_ack_in, wr_en, wr_data, rd_en, err_clr,
    output ext_dir, ext_ack_out, ext_stb_out, rd_data, rx_empty, rx_full,
           tx_empty, tx_full, rx_level, tx_level, err_ovf, err_udf, err_tmo
  );
  modport master (
    output ext_stb_in, ext_ack_in, wr_en, wr_data, rd_en, err_clr,
    input  ext_dir, ext_ack_out, ext_stb_out, rd_data, rx_empty, rx_full,
           tx_empty, tx_full, rx_level, tx_level, err_ovf, err_udf, err_tmo
  );
`else
  modport slave (
    input  ext_stb_in, ext_ack_in, wr_en, wr_data, rd_en, err_clr,
    output ext_dir, ext_ack_out, ext_stb_out, rd_data, rx_empty, rx_full,
           tx_empty, tx_full, rx_level, tx_level, err_ovf, err_udf
  );
  modport master (
    output ext_stb_in, ext_ack_in, wr_en, wr_data, rd_en, err_clr,
    input  ext_dir, ext_ack_out, ext_stb_out, rd_data, rx_empty, rx_full,
           tx_empty, tx_full, rx_level, tx_level, err_ovf, err_udf
  );
`endif
endinterface

// File: rtl/interface_parallel_hs.sv
// Four-phase strobe/ack parallel port with RX/TX FIFOs on one shared bus.
// Optional feature macro: IFP_TIMEOUT_EN (TX handshake abort + sticky err_tmo).
module interface_parallel_hs #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned ADDRESS_WIDTH  = 6,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  inout  wire  [DATA_WIDTH-1:0] ext_data,
  interface_parallel_hs_if.slave bus
);
  localparam int unsigned DW    = DATA_WIDTH;
  localparam int unsigned AW    = ADDRESS_WIDTH;
  localparam int unsigned LW    = AW + 1;
  localparam int unsigned DEPTH = 1 << AW;

  typedef enum logic [2:0] {IDLE, RX_ACK, TX_SETUP, TX_STB, TX_REL} state_t;

  state_t              state_q, state_d;
  logic                ack_q, ack_d, stb_q, stb_d, dir_q, dir_d;
  logic                rx_push, tx_pop, tx_load;
  logic [SYNC_STAGES-1:0] stb_sync_q, ack_sync_q;
  logic                stb_s, ack_s;

  logic [DW-1:0]       rx_mem [DEPTH];
  logic [DW-1:0]       tx_mem [DEPTH];
  logic [AW-1:0]       rx_wr_ptr, rx_rd_ptr, tx_wr_ptr, tx_rd_ptr;
  logic [LW-1:0]       rx_level_q, tx_level_q;
  logic [DW-1:0]       rd_data_q, tx_out_q;
  logic                err_ovf_q, err_udf_q;
  logic                rx_empty, rx_full, tx_empty, tx_full;
  logic                rx_pop_ok, tx_push_ok, tx_pop_ok;

`ifdef IFP_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0]       tmo_cnt_q;
  logic                tmo_expired, tmo_hit, err_tmo_q;
  assign tmo_expired = (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));
  assign bus.err_tmo = err_tmo_q;
`endif

  assign stb_s = stb_sync_q[SYNC_STAGES-1];
  assign ack_s = ack_sync_q[SYNC_STAGES-1];

  assign rx_empty   = (rx_level_q == '0);
  assign rx_full    = (rx_level_q == LW'(DEPTH));
  assign tx_empty   = (tx_level_q == '0);
  assign tx_full    = (tx_level_q == LW'(DEPTH));
  assign rx_pop_ok  = bus.rd_en & ~rx_empty;
  assign tx_push_ok = bus.wr_en & ~tx_full;
  assign tx_pop_ok  = tx_pop & ~tx_empty;

  assign ext_data        = dir_q ? tx_out_q : {DW{1'bz}};
  assign bus.ext_dir     = dir_q;
  assign bus.ext_ack_out = ack_q;
  assign bus.ext_stb_out = stb_q;
  assign bus.rd_data     = rd_data_q;
  assign bus.rx_empty    = rx_empty;
  assign bus.rx_full     = rx_full;
  assign bus.tx_empty    = tx_empty;
  assign bus.tx_full     = tx_full;
  assign bus.rx_level    = rx_level_q;
  assign bus.tx_level    = tx_level_q;
  assign bus.err_ovf     = err_ovf_q;
  assign bus.err_udf     = err_udf_q;

  // Metastability synchronisers for the peer strobe and acknowledge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stb_sync_q <= '0;
      ack_sync_q <= '0;
    end else begin
      stb_sync_q <= {stb_sync_q[SYNC_STAGES-2:0], bus.ext_stb_in};
      ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], bus.ext_ack_in};
    end
  end

  // Handshake state and registered pin outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      stb_q   <= 1'b0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      stb_q   <= stb_d;
      dir_q   <= dir_d;
    end
  end

  // Next state: RX wins over TX in IDLE; a full RX FIFO withholds the ack.
  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    stb_d   = stb_q;
    dir_d   = dir_q;
    rx_push = 1'b0;
    tx_pop  = 1'b0;
    tx_load = 1'b0;
`ifdef IFP_TIMEOUT_EN
    tmo_hit = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (stb_s) begin
          if (!rx_full) begin
            state_d = RX_ACK;
            ack_d   = 1'b1;
            rx_push = 1'b1;
          end
        end else if (!tx_empty) begin
          state_d = TX_SETUP;
          dir_d   = 1'b1;
          tx_load = 1'b1;
        end
      end
      RX_ACK: begin
        if (!stb_s) begin
          state_d = IDLE;
          ack_d   = 1'b0;
        end
      end
      TX_SETUP: begin
        state_d = TX_STB;
        stb_d   = 1'b1;
      end
      TX_STB: begin
        if (ack_s) begin
          state_d = TX_REL;
          stb_d   = 1'b0;
          tx_pop  = 1'b1;
        end
`ifdef IFP_TIMEOUT_EN
        else if (tmo_expired) begin
          state_d = IDLE;
          stb_d   = 1'b0;
          dir_d   = 1'b0;
          tmo_hit = 1'b1;
        end
`endif
      end
      TX_REL: begin
        if (!ack_s) begin
          state_d = IDLE;
          dir_d   = 1'b0;
        end
`ifdef IFP_TIMEOUT_EN
        else if (tmo_expired) begin
          state_d = IDLE;
          dir_d   = 1'b0;
          tmo_hit = 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef IFP_TIMEOUT_EN
  // Cycles spent waiting on the peer; restarts on every state change.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      tmo_cnt_q <= '0;
    else if ((state_d != state_q) || !((state_q == TX_STB) || (state_q == TX_REL)))
      tmo_cnt_q <= '0;
    else
      tmo_cnt_q <= tmo_cnt_q + TW'(1);
  end
`endif

  // FIFO storage; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (rx_push)    rx_mem[rx_wr_ptr] <= ext_data;
    if (tx_push_ok) tx_mem[tx_wr_ptr] <= bus.wr_data;
  end

  // FIFO pointers, levels, read data and the latched TX bus word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_wr_ptr  <= '0;
      rx_rd_ptr  <= '0;
      tx_wr_ptr  <= '0;
      tx_rd_ptr  <= '0;
      rx_level_q <= '0;
      tx_level_q <= '0;
      rd_data_q  <= '0;
      tx_out_q   <= '0;
    end else begin
      if (rx_push)    rx_wr_ptr <= rx_wr_ptr + AW'(1);
      if (rx_pop_ok)  rx_rd_ptr <= rx_rd_ptr + AW'(1);
      if (tx_push_ok) tx_wr_ptr <= tx_wr_ptr + AW'(1);
      if (tx_pop_ok)  tx_rd_ptr <= tx_rd_ptr + AW'(1);
      if (rx_pop_ok)  rd_data_q <= rx_mem[rx_rd_ptr];
      if (tx_load)    tx_out_q  <= tx_mem[tx_rd_ptr];
      case ({rx_push, rx_pop_ok})
        2'b10:   rx_level_q <= rx_level_q + LW'(1);
        2'b01:   rx_level_q <= rx_level_q - LW'(1);
        default: ;
      endcase
      case ({tx_push_ok, tx_pop_ok})
        2'b10:   tx_level_q <= tx_level_q + LW'(1);
        2'b01:   tx_level_q <= tx_level_q - LW'(1);
        default: ;
      endcase
    end
  end

  // Sticky error flags; a clear request takes precedence over new events.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_ovf_q <= 1'b0;
      err_udf_q <= 1'b0;
`ifdef IFP_TIMEOUT_EN
      err_tmo_q <= 1'b0;
`endif
    end else if (bus.err_clr) begin
      err_ovf_q <= 1'b0;
      err_udf_q <= 1'b0;
`ifdef IFP_TIMEOUT_EN
      err_tmo_q <= 1'b0;
`endif
    end else begin
      if (bus.wr_en && tx_full)  err_ovf_q <= 1'b1;
      if (bus.rd_en && rx_empty) err_udf_q <= 1'b1;
`ifdef IFP_TIMEOUT_EN
      if (tmo_hit) err_tmo_q <= 1'b1;
`endif
    end
  end
endmodule

// File: tb/tb_interface_parallel_hs.sv
// Bench for interface_parallel_hs: randomized traffic against queue models.
module tb_interface_parallel_hs;
  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 2;
  localparam int unsigned LW    = AW + 1;
  localparam int unsigned SS    = 2;
  localparam int unsigned TMO   = 64;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          peer_drv = 1'b0;
  logic [DW-1:0] peer_val = '0;
  wire  [DW-1:0] ext_data;

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] rxq[$];
  logic [DW-1:0] txq[$];
  logic [DW-1:0] last_rd = '0;

  assign ext_data = peer_drv ? peer_val : {DW{1'bz}};

  interface_parallel_hs_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus();

  interface_parallel_hs #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .SYNC_STAGES(SS), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .ext_data(ext_data), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [DW-1:0] v);
    bus.wr_en = 1'b1;
    bus.wr_data = v;
    tick();
    bus.wr_en = 1'b0;
    if (txq.size() < DEPTH) txq.push_back(v);
  endtask

  task automatic host_pop(input string tag);
    logic [DW-1:0] exp;
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    exp = last_rd;
    if (rxq.size() > 0) exp = rxq.pop_front();
    last_rd = exp;
    checks++;
    if (bus.rd_data !== exp) begin
      errors++;
      $display("FAIL %s_rd_data: got %02h want %02h", tag, bus.rd_data, exp);
    end
    checks++;
    if (bus.rx_level !== LW'(rxq.size())) begin
      errors++;
      $display("FAIL %s_rx_level: got %0d want %0d", tag, bus.rx_level, rxq.size());
    end
  endtask

  task automatic peer_release(input string tag);
    int n;
    bus.ext_stb_in = 1'b0;
    n = 0;
    while (n < 12 && bus.ext_ack_out) begin tick(); n++; end
    checks++;
    if (bus.ext_ack_out !== 1'b0) begin
      errors++;
      $display("FAIL %s_ack_drop: got %0b want 0", tag, bus.ext_ack_out);
    end
    peer_drv = 1'b0;
  endtask

  // Peer drives a word; if exp_ack=0 the strobe is left asserted for the caller.
  task automatic peer_send(input logic [DW-1:0] v, input bit exp_ack, input string tag);
    int n;
    peer_val = v;
    peer_drv = 1'b1;
    bus.ext_stb_in = 1'b1;
    n = 0;
    while (n < 12 && !bus.ext_ack_out) begin tick(); n++; end
    checks++;
    if (bus.ext_ack_out !== exp_ack) begin
      errors++;
      $display("FAIL %s_ack: got %0b want %0b", tag, bus.ext_ack_out, exp_ack);
    end
    if (bus.ext_ack_out) begin
      rxq.push_back(v);
      peer_release(tag);
    end else if (exp_ack) begin
      bus.ext_stb_in = 1'b0;
      peer_drv = 1'b0;
    end
  endtask

  // Peer receives the TX FIFO head and checks the bus through the whole handshake.
  task automatic peer_recv(input string tag);
    logic [DW-1:0] exp;
    int n;
    exp = (txq.size() > 0) ? txq[0] : '0;
    n = 0;
    while (n < 20 && !bus.ext_dir) begin tick(); n++; end
    checks++;
    if (bus.ext_dir !== 1'b1 || ext_data !== exp) begin
      errors++;
      $display("FAIL %s_setup: dir %0b bus %02h want dir 1 bus %02h", tag, bus.ext_dir, ext_data, exp);
    end
    n = 0;
    while (n < 10 && !bus.ext_stb_out) begin tick(); n++; end
    checks++;
    if (bus.ext_stb_out !== 1'b1 || ext_data !== exp) begin
      errors++;
      $display("FAIL %s_stb: stb %0b bus %02h want stb 1 bus %02h", tag, bus.ext_stb_out, ext_data, exp);
    end
    bus.ext_ack_in = 1'b1;
    n = 0;
    while (n < 10 && bus.ext_stb_out) begin tick(); n++; end
    if (txq.size() > 0) void'(txq.pop_front());
    checks++;
    if (bus.ext_stb_out !== 1'b0 || bus.ext_dir !== 1'b1 || ext_data !== exp ||
        bus.tx_level !== LW'(txq.size())) begin
      errors++;
      $display("FAIL %s_rel: stb %0b dir %0b bus %02h lvl %0d want 0 1 %02h %0d",
               tag, bus.ext_stb_out, bus.ext_dir, ext_data, bus.tx_level, exp, txq.size());
    end
    bus.ext_ack_in = 1'b0;
    n = 0;
    while (n < 10 && bus.ext_dir) begin tick(); n++; end
    checks++;
    if (bus.ext_dir !== 1'b0) begin
      errors++;
      $display("FAIL %s_dir_release: got %0b want 0", tag, bus.ext_dir);
    end
  endtask

  task automatic test_reset();
    bus.ext_stb_in = 1'b0; bus.ext_ack_in = 1'b0; bus.wr_en = 1'b0;
    bus.wr_data = '0; bus.rd_en = 1'b0; bus.err_clr = 1'b0;
    rst = 1'b0;
    #22;
    checks++;
    if (bus.ext_dir !== 1'b0 || bus.ext_ack_out !== 1'b0 || bus.ext_stb_out !== 1'b0 ||
        bus.rd_data !== '0 || bus.rx_level !== '0 || bus.tx_level !== '0 ||
        bus.rx_empty !== 1'b1 || bus.tx_empty !== 1'b1 || bus.rx_full !== 1'b0 ||
        bus.tx_full !== 1'b0 || bus.err_ovf !== 1'b0 || bus.err_udf !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: dir %0b ack %0b stb %0b rd %02h rxl %0d txl %0d want all idle",
               bus.ext_dir, bus.ext_ack_out, bus.ext_stb_out, bus.rd_data, bus.rx_level, bus.tx_level);
    end
`ifdef IFP_TIMEOUT_EN
    checks++;
    if (bus.err_tmo !== 1'b0) begin
      errors++;
      $display("FAIL reset_err_tmo: got %0b want 0", bus.err_tmo);
    end
`endif
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset_traffic();
    int n;
    host_write(8'($urandom));
    n = 0;
    while (n < 20 && !bus.ext_stb_out) begin tick(); n++; end
    checks++;
    if (bus.ext_stb_out !== 1'b1) begin
      errors++;
      $display("FAIL rst_traffic_reach_stb: got %0b want 1", bus.ext_stb_out);
    end
    rst = 1'b0;
    #2;
    txq.delete();
    rxq.delete();
    last_rd = '0;
    checks++;
    if (bus.ext_dir !== 1'b0 || bus.ext_stb_out !== 1'b0 || bus.tx_level !== '0 ||
        bus.tx_empty !== 1'b1) begin
      errors++;
      $display("FAIL rst_traffic: dir %0b stb %0b txl %0d want 0 0 0",
               bus.ext_dir, bus.ext_stb_out, bus.tx_level);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_rx();
    int n;
    peer_val = 8'hA5;
    peer_drv = 1'b1;
    bus.ext_stb_in = 1'b1;
    n = 0;
    while (n < 12 && !bus.ext_ack_out) begin tick(); n++; end
    checks++;
    if (n != SS + 1) begin
      errors++;
      $display("FAIL rx_ack_latency: got %0d want %0d", n, SS + 1);
    end
    rxq.push_back(8'hA5);
    checks++;
    if (bus.rx_level !== LW'(1)) begin
      errors++;
      $display("FAIL rx_level_one: got %0d want 1", bus.rx_level);
    end
    peer_release("rx");
    host_pop("rx");
    checks++;
    if (bus.rx_empty !== 1'b1) begin
      errors++;
      $display("FAIL rx_empty_after_pop: got %0b want 1", bus.rx_empty);
    end
  endtask

  task automatic test_tx();
    host_write(8'h3C);
    host_write(8'h7E);
    checks++;
    if (bus.tx_level !== LW'(2) || bus.ext_dir !== 1'b1 || bus.ext_stb_out !== 1'b0 ||
        ext_data !== 8'h3C) begin
      errors++;
      $display("FAIL tx_setup_first: lvl %0d dir %0b stb %0b bus %02h want 2 1 0 3c",
               bus.tx_level, bus.ext_dir, bus.ext_stb_out, ext_data);
    end
    peer_recv("tx0");
    peer_recv("tx1");
  endtask

  task automatic test_full();
    logic [DW-1:0] v5;
    int n;
    for (int k = 0; k < DEPTH; k++) peer_send(8'($urandom), 1'b1, "full_fill");
    checks++;
    if (bus.rx_full !== 1'b1 || bus.rx_level !== LW'(DEPTH)) begin
      errors++;
      $display("FAIL full_flag: full %0b lvl %0d want 1 %0d", bus.rx_full, bus.rx_level, DEPTH);
    end
    v5 = 8'($urandom);
    peer_send(v5, 1'b0, "full_backpressure");
    host_pop("full_pop");
    n = 0;
    while (n < 12 && !bus.ext_ack_out) begin tick(); n++; end
    checks++;
    if (bus.ext_ack_out !== 1'b1) begin
      errors++;
      $display("FAIL full_resume_ack: got %0b want 1", bus.ext_ack_out);
    end
    if (bus.ext_ack_out) begin
      rxq.push_back(v5);
      peer_release("full_resume");
    end else begin
      bus.ext_stb_in = 1'b0;
      peer_drv = 1'b0;
    end
    for (int k = 0; k < DEPTH; k++) host_pop("full_drain");
  endtask

  task automatic test_errors();
    logic [DW-1:0] hold;
    for (int k = 0; k < DEPTH; k++) host_write(8'($urandom));
    host_write(8'hFF);
    checks++;
    if (bus.err_ovf !== 1'b1 || bus.tx_level !== LW'(DEPTH)) begin
      errors++;
      $display("FAIL err_ovf_set: ovf %0b lvl %0d want 1 %0d", bus.err_ovf, bus.tx_level, DEPTH);
    end
    hold = last_rd;
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    tick();
    checks++;
    if (bus.err_udf !== 1'b1 || bus.rx_level !== '0 || bus.rd_data !== hold ||
        bus.err_ovf !== 1'b1) begin
      errors++;
      $display("FAIL err_udf_set: udf %0b ovf %0b lvl %0d rd %02h want 1 1 0 %02h",
               bus.err_udf, bus.err_ovf, bus.rx_level, bus.rd_data, hold);
    end
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    checks++;
    if (bus.err_ovf !== 1'b0 || bus.err_udf !== 1'b0 || bus.tx_level !== LW'(DEPTH) ||
        bus.rx_level !== '0) begin
      errors++;
      $display("FAIL err_clr: ovf %0b udf %0b txl %0d rxl %0d want 0 0 %0d 0",
               bus.err_ovf, bus.err_udf, bus.tx_level, bus.rx_level, DEPTH);
    end
    for (int k = 0; k < DEPTH; k++) peer_recv("err_drain");
  endtask

  task automatic test_priority();
    logic [DW-1:0] r, w;
    int n;
    r = 8'($urandom);
    w = 8'($urandom);
    peer_val = r;
    peer_drv = 1'b1;
    bus.ext_stb_in = 1'b1;
    tick();
    host_write(w);
    n = 0;
    while (n < 12 && !bus.ext_ack_out && !bus.ext_dir) begin tick(); n++; end
    checks++;
    if (bus.ext_ack_out !== 1'b1 || bus.ext_dir !== 1'b0) begin
      errors++;
      $display("FAIL prio_rx_first: ack %0b dir %0b want 1 0", bus.ext_ack_out, bus.ext_dir);
    end
    if (bus.ext_ack_out) begin
      rxq.push_back(r);
      peer_release("prio_rx");
    end else begin
      bus.ext_stb_in = 1'b0;
      peer_drv = 1'b0;
    end
    peer_recv("prio_tx");
    host_pop("prio_pop");
`ifdef IFP_TIMEOUT_EN
    w = 8'($urandom);
    host_write(w);
    n = 0;
    while (n < TMO + 20 && !bus.err_tmo) begin tick(); n++; end
    checks++;
    if (bus.err_tmo !== 1'b1 || bus.ext_dir !== 1'b0 || bus.ext_stb_out !== 1'b0 ||
        bus.tx_level !== LW'(1)) begin
      errors++;
      $display("FAIL tmo_abort: tmo %0b dir %0b stb %0b lvl %0d want 1 0 0 1",
               bus.err_tmo, bus.ext_dir, bus.ext_stb_out, bus.tx_level);
    end
    peer_recv("tmo_retry");
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    checks++;
    if (bus.err_tmo !== 1'b0) begin
      errors++;
      $display("FAIL tmo_clr: got %0b want 0", bus.err_tmo);
    end
`endif
  endtask

  task automatic test_random();
    int n;
    for (int it = 0; it < 10; it++) begin
      n = $urandom_range(1, DEPTH);
      for (int k = 0; k < n; k++) peer_send(8'($urandom), 1'b1, "rnd_rx");
      repeat ($urandom_range(0, 3)) tick();
      checks++;
      if (bus.rx_level !== LW'(rxq.size())) begin
        errors++;
        $display("FAIL rnd_rx_level: got %0d want %0d", bus.rx_level, rxq.size());
      end
      for (int k = 0; k < n; k++) host_pop("rnd_pop");
      n = $urandom_range(1, DEPTH);
      for (int k = 0; k < n; k++) host_write(8'($urandom));
      checks++;
      if (bus.tx_level !== LW'(txq.size())) begin
        errors++;
        $display("FAIL rnd_tx_level: got %0d want %0d", bus.tx_level, txq.size());
      end
      for (int k = 0; k < n; k++) peer_recv("rnd_tx");
    end
  endtask

  initial begin
    test_reset();
    test_reset_traffic();
    test_rx();
    test_tx();
    test_full();
    test_errors();
    test_priority();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
